// File: rtl/saturn_fetch_if.sv
// Fetch-stage bus: ROM read port, redirect request and decoder nibble stream.
interface saturn_fetch_if #(
  parameter int DEPTH = 4
) ();
  logic [19:0]             rom_address;
  logic                    rom_enable;
  logic [3:0]              rom_nibble;
  logic                    redirect;
  logic [19:0]             redirect_pc;
  logic                    nib_valid;
  logic                    nib_ready;
  logic [3:0]              nib_data;
  logic [19:0]             nib_pc;
  logic [$clog2(DEPTH):0]  level;

  modport master (
    output rom_address, rom_enable, nib_valid, nib_data, nib_pc, level,
    input  rom_nibble, redirect, redirect_pc, nib_ready
  );

  modport slave (
    input  rom_address, rom_enable, nib_valid, nib_data, nib_pc, level,
    output rom_nibble, redirect, redirect_pc, nib_ready
  );
endinterface

// File: rtl/saturn_fetch.sv
// Saturn instruction prefetch: issues nibble ROM reads ahead of the decoder
// and buffers returned nibbles, tagged with their address, in a small FIFO.
module saturn_fetch #(
  parameter int          DEPTH    = 4,
  parameter logic [19:0] RESET_PC = 20'h00000
) (
  input logic            clk,
  input logic            reset,
  saturn_fetch_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef logic [CW:0] credit_t;
  localparam credit_t DEPTH_C = credit_t'(DEPTH);

  logic [19:0]   fetch_ptr;
  logic          inflight;
  logic [19:0]   inflight_pc;
  logic [3:0]    mem_nib [DEPTH];
  logic [19:0]   mem_pc  [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic    issue;
  logic    push;
  logic    pop;
  credit_t credit;

  // Credit counts the outstanding read as occupied so a return never overflows;
  // only registered state is used, keeping nib_ready off the rom_enable path.
  always_comb begin
    credit = credit_t'(count) + credit_t'(inflight);
    issue  = !reset && !bus.redirect && (credit < DEPTH_C);
    push   = inflight && !bus.redirect;
    pop    = (count != '0) && bus.nib_ready && !bus.redirect;
  end

  assign bus.rom_enable  = issue;
  assign bus.rom_address = fetch_ptr;
  assign bus.nib_valid   = (count != '0);
  assign bus.nib_data    = mem_nib[rd_ptr];
  assign bus.nib_pc      = mem_pc[rd_ptr];
  assign bus.level       = count;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_ptr   <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else if (bus.redirect) begin
      fetch_ptr <= bus.redirect_pc;
      inflight  <= 1'b0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fetch_ptr   <= fetch_ptr + 20'd1;
        inflight_pc <= fetch_ptr;
      end
      if (push) begin
        mem_nib[wr_ptr] <= bus.rom_nibble;
        mem_pc[wr_ptr]  <= inflight_pc;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule
